// File: rtl/rs_alu_sched.sv
// rs_alu_sched: allocation and issue scheduler for the ALU reservation station.
//
// Each cycle it offers the two lowest-indexed free slots to the decoder. It
// raises stall when an enabled dispatch has no slot. It also selects the two
// oldest operand-ready entries for the two ALU pipes. Relative entry age is
// kept in an RS_SIZE x RS_SIZE age matrix, where older[j][i]=1 means that
// entry j is older than entry i.
//
// All outputs are combinational from the current inputs and the age state.
// The RS samples them on the same clk edge.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset (clears the age matrix)
//   rdy           global enable; age state frozen and outputs idle when low
//   busy          per-entry occupied flag from the RS
//   ready_n       active-low per-entry "both operands available"
//   alu_enable_1  dispatch request, slot 1 (program-older)
//   alu_enable_2  dispatch request, slot 2
//   issue_hold    ALU pipes cannot accept this cycle
//   alloc_addr_1/2  slots offered to dispatch 1/2, or NONE (all ones)
//   issue_addr_1/2  oldest / second-oldest issuable entry, or NONE
//   stall         an enabled dispatch cannot be placed this cycle
//
// Handshake: a dispatch is accepted on a clk edge where its enable is high,
// stall is low and rdy is high. An issue address is valid whenever it is not
// NONE. No back-pressure exists beyond issue_hold.
module rs_alu_sched #(
  parameter int RS_SIZE = 7,
  parameter int SEL_W   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic [RS_SIZE-1:0] busy,
  input  logic [RS_SIZE-1:0] ready_n,
  input  logic               alu_enable_1,
  input  logic               alu_enable_2,
  input  logic               issue_hold,
  output logic [SEL_W-1:0]   alloc_addr_1,
  output logic [SEL_W-1:0]   alloc_addr_2,
  output logic [SEL_W-1:0]   issue_addr_1,
  output logic [SEL_W-1:0]   issue_addr_2,
  output logic               stall
);

  localparam logic [SEL_W-1:0] NONE = {SEL_W{1'b1}};

  // older[j][i] = 1 : entry j is older than entry i
  logic [RS_SIZE-1:0][RS_SIZE-1:0] older;
  logic [RS_SIZE-1:0][RS_SIZE-1:0] older_nxt;

  logic               active;
  logic               fire_1;
  logic               fire_2;
  logic [RS_SIZE-1:0] cand;
  logic [RS_SIZE-1:0] cand2;

  // Return the candidate that no other candidate is older than.
  // The scan runs downward, so among equals the lowest index is the last
  // match and therefore wins.
  function automatic logic [SEL_W-1:0] pick_oldest(
    input logic [RS_SIZE-1:0]              c,
    input logic [RS_SIZE-1:0][RS_SIZE-1:0] m
  );
    logic [SEL_W-1:0] sel;
    logic             blocked;
    sel = NONE;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      blocked = 1'b0;
      for (int j = 0; j < RS_SIZE; j++) begin
        if (c[j] && m[j][i]) blocked = 1'b1;
      end
      if (c[i] && !blocked) sel = SEL_W'(i);
    end
    return sel;
  endfunction

  assign active = !rst && rdy;

  // Allocation: the first two free slots in index order.
  always_comb begin
    alloc_addr_1 = NONE;
    alloc_addr_2 = NONE;
    if (active) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (!busy[i]) begin
          if (alloc_addr_1 == NONE)      alloc_addr_1 = SEL_W'(i);
          else if (alloc_addr_2 == NONE) alloc_addr_2 = SEL_W'(i);
        end
      end
    end
  end

  // Dispatch is all-or-nothing. If either enabled slot cannot be placed,
  // neither dispatch fires.
  always_comb begin
    stall  = !active
          || (alu_enable_1 && alloc_addr_1 == NONE)
          || (alu_enable_2 && alloc_addr_2 == NONE);
    fire_1 = !stall && alu_enable_1;
    fire_2 = !stall && alu_enable_2;
  end

  // Issue selection: oldest candidate, then oldest of the remaining ones.
  always_comb begin
    cand  = (active && !issue_hold) ? (busy & ~ready_n) : '0;
    issue_addr_1 = pick_oldest(cand, older);
    cand2 = cand;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (issue_addr_1 == SEL_W'(i)) cand2[i] = 1'b0;
    end
    issue_addr_2 = pick_oldest(cand2, older);
  end

  // A newly allocated entry is younger than everything currently busy.
  // Clearing its row and loading its column with busy records that.
  // When both dispatches fire, dispatch 1 is program-older than dispatch 2.
  // That pair bit is written last, so it overrides the cleared row.
  always_comb begin
    older_nxt = older;
    for (int a = 0; a < RS_SIZE; a++) begin
      if (fire_1 && alloc_addr_1 == SEL_W'(a)) begin
        older_nxt[a] = '0;
        for (int j = 0; j < RS_SIZE; j++) older_nxt[j][a] = busy[j];
      end
    end
    for (int a = 0; a < RS_SIZE; a++) begin
      if (fire_2 && alloc_addr_2 == SEL_W'(a)) begin
        older_nxt[a] = '0;
        for (int j = 0; j < RS_SIZE; j++) older_nxt[j][a] = busy[j];
      end
    end
    if (fire_1 && fire_2) begin
      for (int a = 0; a < RS_SIZE; a++) begin
        for (int b = 0; b < RS_SIZE; b++) begin
          if (alloc_addr_1 == SEL_W'(a) && alloc_addr_2 == SEL_W'(b))
            older_nxt[a][b] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)      older <= '0;
    else if (rdy) older <= older_nxt;
  end

endmodule
